// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Plays one of four fixed four-note melodies as a square wave. Each note
//   lasts NOTE_CYCLES clocks. The square wave toggles every half_period clocks,
//   using the value from the note table. A half_period of 0 is a rest.
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   reset       synchronous active-high reset
//   enable      level request to play; low returns to idle
//   melody_sel  0 jump, 1 win, 2 lose, 3 silent; latched when play starts
//   sound_out   registered square-wave audio bit
//   busy        registered; high while a melody is playing
//   done        registered one-cycle pulse when the final note ends
module tone_sequencer #(
  parameter int unsigned NOTE_CYCLES = 3_125_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] melody_sel,
  output logic       sound_out,
  output logic       busy,
  output logic       done
);

  localparam logic [23:0] DUR_LAST = 24'(NOTE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  melody_reg, melody_next;
  logic [1:0]  note_reg, note_next;
  logic [23:0] dur_reg, dur_next;
  logic [15:0] tone_reg, tone_next;
  logic        sound_reg, sound_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [15:0] half_period;

  // Note table: half-periods in clk cycles, 0 = rest.
  always_comb begin
    half_period = 16'd0;
    case ({melody_reg, note_reg})
      4'b00_00: half_period = 16'd23889;
      4'b00_01: half_period = 16'd15944;
      4'b01_00: half_period = 16'd23889;
      4'b01_01: half_period = 16'd18960;
      4'b01_10: half_period = 16'd15944;
      4'b01_11: half_period = 16'd11945;
      4'b10_00: half_period = 16'd31888;
      4'b10_01: half_period = 16'd37921;
      4'b10_10: half_period = 16'd47778;
      default:  half_period = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      melody_reg <= 2'd0;
      note_reg   <= 2'd0;
      dur_reg    <= 24'd0;
      tone_reg   <= 16'd0;
      sound_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      melody_reg <= melody_next;
      note_reg   <= note_next;
      dur_reg    <= dur_next;
      tone_reg   <= tone_next;
      sound_reg  <= sound_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    melody_next = melody_reg;
    note_next   = note_reg;
    dur_next    = dur_reg;
    tone_next   = tone_reg;
    sound_next  = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        note_next = 2'd0;
        dur_next  = 24'd0;
        tone_next = 16'd0;
        if (enable) begin
          state_next  = PLAY;
          melody_next = melody_sel;
          busy_next   = 1'b1;
        end
      end

      PLAY: begin
        // The end of the last note wins over a simultaneous enable drop.
        // The done pulse is still issued, and HOLD then returns to IDLE.
        if (dur_reg == DUR_LAST && note_reg == 2'd3) begin
          state_next = HOLD;
          done_next  = 1'b1;
          note_next  = 2'd0;
          dur_next   = 24'd0;
          tone_next  = 16'd0;
        end else if (!enable) begin
          state_next = IDLE;
          note_next  = 2'd0;
          dur_next   = 24'd0;
          tone_next  = 16'd0;
        end else begin
          busy_next = 1'b1;
          if (dur_reg == DUR_LAST) begin
            // Note boundary: every note restarts its wave low.
            dur_next  = 24'd0;
            tone_next = 16'd0;
            note_next = note_reg + 2'd1;
          end else begin
            dur_next = dur_reg + 24'd1;
            if (half_period == 16'd0) begin
              tone_next = 16'd0;
            end else if (tone_reg == half_period - 16'd1) begin
              tone_next  = 16'd0;
              sound_next = ~sound_reg;
            end else begin
              tone_next  = tone_reg + 16'd1;
              sound_next = sound_reg;
            end
          end
        end
      end

      HOLD: begin
        if (!enable) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sound_out = sound_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Testbench for tone_sequencer.
// Instance a has a long note length, so the note table tones are audible.
// Instance b has a very short note length, so the sequencing scenarios stay quick.
// A model predicts each instance's outputs on every cycle from the melody
// position: note = t / N, position in note k = t % N, and wave = (k / hp) odd.
module tb_tone_sequencer;

  localparam int N_A = 12000;
  localparam int N_B = 6;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, en_a = 1'b0;
  logic       rst_b = 1'b1, en_b = 1'b0;
  logic [1:0] sel_a = 2'd0, sel_b = 2'd0;
  logic       sound_a, busy_a, done_a;
  logic       sound_b, busy_b, done_b;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  tone_sequencer #(.NOTE_CYCLES(N_A)) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .melody_sel(sel_a),
    .sound_out(sound_a), .busy(busy_a), .done(done_a)
  );

  tone_sequencer #(.NOTE_CYCLES(N_B)) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .melody_sel(sel_b),
    .sound_out(sound_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- behavioural model ----------------
  int hp_tab [4][4] = '{
    '{23889, 15944, 0, 0},
    '{23889, 18960, 15944, 11945},
    '{31888, 37921, 47778, 0},
    '{0, 0, 0, 0}
  };

  // mode: 0 idle, 1 playing, 2 holding after completion
  int   m_mode [2] = '{0, 0};
  int   m_t    [2] = '{0, 0};
  int   m_mel  [2] = '{0, 0};
  logic e_sound [2] = '{1'b0, 1'b0};
  logic e_busy  [2] = '{1'b0, 1'b0};
  logic e_done  [2] = '{1'b0, 1'b0};

  function automatic logic tone_at(input int mel, input int t, input int n);
    int hp;
    int k;
    hp = hp_tab[mel][(t / n) % 4];
    k  = t % n;
    if (hp == 0) return 1'b0;
    return ((k / hp) % 2) == 1;
  endfunction

  task automatic model_step(input int d, input logic r, input logic e,
                            input logic [1:0] s, input int n);
    logic pulse;
    pulse = 1'b0;
    if (r) begin
      m_mode[d] = 0;
      m_t[d]    = 0;
      m_mel[d]  = 0;
    end else begin
      case (m_mode[d])
        0: if (e) begin m_mode[d] = 1; m_t[d] = 0; m_mel[d] = int'(s); end
        1: begin
          if (m_t[d] == 4 * n - 1) begin
            m_mode[d] = 2;
            pulse     = 1'b1;
          end else if (!e) begin
            m_mode[d] = 0;
          end else begin
            m_t[d] = m_t[d] + 1;
          end
        end
        default: if (!e) m_mode[d] = 0;
      endcase
    end
    e_busy[d]  = (m_mode[d] == 1);
    e_done[d]  = pulse;
    e_sound[d] = (m_mode[d] == 1) ? tone_at(m_mel[d], m_t[d], n) : 1'b0;
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, en_a, sel_a, N_A);
    model_step(1, rst_b, en_b, sel_b, N_B);
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    // Per-cycle comparison of both instances against the model.
    fork
      forever begin
        @(negedge clk);
        if (checking) begin
          total++;
          if ({sound_a, busy_a, done_a} !== {e_sound[0], e_busy[0], e_done[0]}) begin
            bad++;
            $display("FAIL cycle_a t=%0d: got sound/busy/done=%b%b%b expected %b%b%b",
                     m_t[0], sound_a, busy_a, done_a, e_sound[0], e_busy[0], e_done[0]);
          end
          total++;
          if ({sound_b, busy_b, done_b} !== {e_sound[1], e_busy[1], e_done[1]}) begin
            bad++;
            $display("FAIL cycle_b t=%0d: got sound/busy/done=%b%b%b expected %b%b%b",
                     m_t[1], sound_b, busy_b, done_b, e_sound[1], e_busy[1], e_done[1]);
          end
        end
      end
    join_none

    // Reset state, including reset overriding a high enable.
    tick;
    checking = 1'b1;
    tick;
    chk("reset_busy_a", int'(busy_a), 0);
    chk("reset_sound_a", int'(sound_a), 0);
    chk("reset_done_b", int'(done_b), 0);
    en_b = 1'b1;
    tick;
    chk("reset_over_enable", int'(busy_b), 0);
    en_b = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick;
    $display("txn reset: busy_a=%b busy_b=%b", busy_a, busy_b);

    // b: jump, full length, then stay in hold with enable high.
    sel_b = 2'd0; en_b = 1'b1;
    tick;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 4 * N_B; i++) begin
      busy_cnt += int'(busy_b);
      done_cnt += int'(done_b);
      tick;
    end
    chk("jump_busy_cycles", busy_cnt, 24);
    chk("jump_no_early_done", done_cnt, 0);
    chk("jump_done_pulse", int'(done_b), 1);
    tick;
    chk("jump_done_one_cycle", int'(done_b), 0);
    tick; tick;
    chk("hold_no_replay", int'(busy_b), 0);
    en_b = 1'b0;
    tick; tick;
    $display("txn jump_b: busy_cycles=%0d", busy_cnt);

    // b: lose, with melody_sel changed mid-run; it still completes.
    sel_b = 2'd2; en_b = 1'b1;
    tick;
    for (int i = 0; i < 4 * N_B; i++) begin
      if (i == 10) sel_b = 2'd1;
      tick;
    end
    chk("lose_done", int'(done_b), 1);
    en_b = 1'b0;
    tick; tick;
    $display("txn lose_b: sel changed mid-run");

    // b: win aborted at t=9, then a restart with a new selection.
    sel_b = 2'd1; en_b = 1'b1;
    tick;
    for (int i = 0; i < 9; i++) tick;
    en_b = 1'b0;
    tick;
    chk("abort_busy", int'(busy_b), 0);
    chk("abort_no_done", int'(done_b), 0);
    sel_b = 2'd0; en_b = 1'b1;
    tick;
    busy_cnt = 0;
    for (int i = 0; i < 4 * N_B; i++) begin
      busy_cnt += int'(busy_b);
      tick;
    end
    chk("restart_full_length", busy_cnt, 24);
    chk("restart_done", int'(done_b), 1);
    en_b = 1'b0;
    tick; tick;
    $display("txn abort_restart_b: busy_cycles=%0d", busy_cnt);

    // b: reset pulse mid-play with enable high.
    sel_b = 2'd3; en_b = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) tick;
    rst_b = 1'b1;
    tick;
    chk("midreset_busy", int'(busy_b), 0);
    chk("midreset_done", int'(done_b), 0);
    rst_b = 1'b0;
    tick;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 4 * N_B; i++) begin
      busy_cnt += int'(busy_b);
      done_cnt += int'(done_b);
      tick;
    end
    chk("midreset_fresh_length", busy_cnt, 24);
    chk("midreset_no_stale_done", done_cnt, 0);
    chk("silent_done", int'(done_b), 1);
    en_b = 1'b0;
    tick; tick;
    $display("txn midreset_b: busy_cycles=%0d", busy_cnt);

    // b: enable dropped on the very cycle the final note ends.
    sel_b = 2'd1; en_b = 1'b1;
    tick;
    for (int i = 0; i < 4 * N_B - 1; i++) tick;
    en_b = 1'b0;
    tick;
    chk("lastdrop_done", int'(done_b), 1);
    tick;
    chk("lastdrop_idle_done", int'(done_b), 0);
    en_b = 1'b1;
    tick;
    chk("lastdrop_replay_from_idle", int'(busy_b), 1);
    en_b = 1'b0;
    tick; tick;
    $display("txn lastdrop_b: done then idle");

    // a: full win melody with audible tones; selection changed mid-run.
    sel_a = 2'd1; en_a = 1'b1;
    tick;
    for (int i = 0; i < 4 * N_A; i++) begin
      if (i == 20000) sel_a = 2'd2;
      if (i == 0)     chk("win_first_sound", int'(sound_a), 0);
      if (i == 47944) chk("win_c6_before_toggle", int'(sound_a), 0);
      if (i == 47945) chk("win_c6_toggle", int'(sound_a), 1);
      if (i == 47999) chk("win_last_busy", int'(busy_a), 1);
      tick;
    end
    chk("win_done", int'(done_a), 1);
    chk("win_end_sound", int'(sound_a), 0);
    tick;
    chk("win_hold_busy", int'(busy_a), 0);
    en_a = 1'b0;
    tick; tick;
    $display("txn win_a: full melody");

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
